// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 16-byte lines.
// Hits answer one cycle after the request. Misses fetch the whole line
// from mem_ctrler over a valid/ready handshake, install it, then answer.
// flush invalidates every line. If flush arrives during a fill, that
// fill still completes but the line is thrown away.
module icache #(
    parameter int INDEX_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rdy,
    input  logic         flush,
    input  logic         valid_from_fetcher,
    input  logic [31:0]  addr_from_fetcher,
    output logic         ready_to_fetcher,
    output logic [31:0]  inst_to_fetcher,
    output logic         valid_to_mem,
    output logic [31:0]  addr_to_mem,
    input  logic         ready_from_mem,
    input  logic [127:0] data_from_mem
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 32 - 4 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } state_e;

    // Pick 32-bit word w out of a little-endian 128-bit line.
    function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] w);
        logic [31:0] r;
        case (w)
            2'd0:    r = line[31:0];
            2'd1:    r = line[63:32];
            2'd2:    r = line[95:64];
            default: r = line[127:96];
        endcase
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic                 flushed_q, flushed_d;
    logic                 ready_q, ready_d;
    logic [31:0]          inst_q, inst_d;
    logic                 vmem_q, vmem_d;
    logic [31:0]          amem_q, amem_d;
    logic [1:0]           word_q, word_d;

    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [127:0]         data_mem [LINES];

    logic [INDEX_WIDTH-1:0] req_idx_s;
    logic [TAG_W-1:0]       req_tag_s;
    logic [INDEX_WIDTH-1:0] fill_idx_s;
    logic [TAG_W-1:0]       fill_tag_s;
    logic                   hit_s;
    logic                   install_s;
    logic                   unused_s;

    assign req_idx_s  = addr_from_fetcher[4+INDEX_WIDTH-1:4];
    assign req_tag_s  = addr_from_fetcher[31:4+INDEX_WIDTH];
    assign fill_idx_s = amem_q[4+INDEX_WIDTH-1:4];
    assign fill_tag_s = amem_q[31:4+INDEX_WIDTH];
    // A same-cycle flush forces a miss, because the line is being invalidated.
    assign hit_s      = valid_q[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s) && !flush;
    assign unused_s   = ^{addr_from_fetcher[1:0], amem_q[3:0]};

    assign ready_to_fetcher = ready_q;
    assign inst_to_fetcher  = inst_q;
    assign valid_to_mem     = vmem_q;
    assign addr_to_mem      = amem_q;

    // Next-state and output logic. Every register holds while rdy is low.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        flushed_d = flushed_q;
        ready_d   = ready_q;
        inst_d    = inst_q;
        vmem_d    = vmem_q;
        amem_d    = amem_q;
        word_d    = word_q;
        install_s = 1'b0;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    ready_d = 1'b0;
                    if (flush) begin
                        valid_d = {LINES{1'b0}};
                    end else begin
                        valid_d = valid_q;
                    end
                    // The cycle after a hit pulse, the fetcher's valid is still stale, so skip it.
                    if (ready_q) begin
                        state_d = IDLE;
                    end else if (valid_from_fetcher) begin
                        if (hit_s) begin
                            inst_d  = sel_word(data_mem[req_idx_s], addr_from_fetcher[3:2]);
                            ready_d = 1'b1;
                        end else begin
                            vmem_d    = 1'b1;
                            amem_d    = {addr_from_fetcher[31:4], 4'b0000};
                            word_d    = addr_from_fetcher[3:2];
                            flushed_d = 1'b0;
                            state_d   = MISS;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                MISS: begin
                    // mem_ctrler cannot abort a fill, so only record the flush here.
                    if (flush) begin
                        valid_d   = {LINES{1'b0}};
                        flushed_d = 1'b1;
                    end else begin
                        valid_d   = valid_q;
                    end
                    if (ready_from_mem) begin
                        vmem_d    = 1'b0;
                        flushed_d = 1'b0;
                        if (flushed_q || flush) begin
                            state_d = IDLE;
                        end else begin
                            install_s           = 1'b1;
                            valid_d[fill_idx_s] = 1'b1;
                            inst_d              = sel_word(data_from_mem, word_q);
                            ready_d             = 1'b1;
                            state_d             = RESP;
                        end
                    end else begin
                        state_d = MISS;
                    end
                end
                RESP: begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                    if (flush) begin
                        valid_d = {LINES{1'b0}};
                    end else begin
                        valid_d = valid_q;
                    end
                end
                default: begin
                    ready_d = 1'b0;
                    vmem_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= {LINES{1'b0}};
            flushed_q <= 1'b0;
            ready_q   <= 1'b0;
            inst_q    <= 32'h0000_0000;
            vmem_q    <= 1'b0;
            amem_q    <= 32'h0000_0000;
            word_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            flushed_q <= flushed_d;
            ready_q   <= ready_d;
            inst_q    <= inst_d;
            vmem_q    <= vmem_d;
            amem_q    <= amem_d;
            word_q    <= word_d;
        end
    end

    // Tag and data arrays. They have no reset because the valid bits guard them.
    always_ff @(posedge clk) begin
        if (install_s) begin
            tag_mem[fill_idx_s]  <= fill_tag_s;
            data_mem[fill_idx_s] <= data_from_mem;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge, away from the rising clock edge.
module tb_icache;

    logic         clk;
    logic         rst_n;
    logic         rdy;
    logic         flush;
    logic         valid_from_fetcher;
    logic [31:0]  addr_from_fetcher;
    logic         ready_to_fetcher;
    logic [31:0]  inst_to_fetcher;
    logic         valid_to_mem;
    logic [31:0]  addr_to_mem;
    logic         ready_from_mem;
    logic [127:0] data_from_mem;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] L1 = 128'h33221100_DDCCBBAA_44332211_88776655;
    localparam logic [127:0] L2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] L3 = 128'hCAFEF00D_DEADBEEF_12345678_9ABCDEF0;
    localparam logic [127:0] L4 = 128'h44444444_33333333_22222222_11111111;

    icache #(.INDEX_WIDTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rdy                (rdy),
        .flush              (flush),
        .valid_from_fetcher (valid_from_fetcher),
        .addr_from_fetcher  (addr_from_fetcher),
        .ready_to_fetcher   (ready_to_fetcher),
        .inst_to_fetcher    (inst_to_fetcher),
        .valid_to_mem       (valid_to_mem),
        .addr_to_mem        (addr_to_mem),
        .ready_from_mem     (ready_from_mem),
        .data_from_mem      (data_from_mem)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Request that must miss: the line is filled lat cycles after the request and answered once.
    task automatic fetch_miss(input string tag, input logic [31:0] a, input logic [127:0] line,
                              input int lat, input logic [31:0] exp_inst, input logic fl);
        @(negedge clk);
        valid_from_fetcher = 1'b1;
        addr_from_fetcher  = a;
        flush              = fl;
        @(negedge clk);
        flush = 1'b0;
        check32({tag, "_vmem"}, {31'd0, valid_to_mem}, 32'd1);
        check32({tag, "_amem"}, addr_to_mem, {a[31:4], 4'b0000});
        check32({tag, "_noready"}, {31'd0, ready_to_fetcher}, 32'd0);
        repeat (lat - 1) @(negedge clk);
        check32({tag, "_vmem_held"}, {31'd0, valid_to_mem}, 32'd1);
        ready_from_mem = 1'b1;
        data_from_mem  = line;
        @(negedge clk);
        ready_from_mem     = 1'b0;
        valid_from_fetcher = 1'b0;
        check32({tag, "_ready"}, {31'd0, ready_to_fetcher}, 32'd1);
        check32({tag, "_inst"}, inst_to_fetcher, exp_inst);
        check32({tag, "_vmem_drop"}, {31'd0, valid_to_mem}, 32'd0);
        @(negedge clk);
        check32({tag, "_pulse_end"}, {31'd0, ready_to_fetcher}, 32'd0);
    endtask

    // Request that must hit: answered the next cycle with no memory traffic.
    task automatic fetch_hit(input string tag, input logic [31:0] a, input logic [31:0] exp_inst);
        @(negedge clk);
        valid_from_fetcher = 1'b1;
        addr_from_fetcher  = a;
        @(negedge clk);
        valid_from_fetcher = 1'b0;
        check32({tag, "_ready"}, {31'd0, ready_to_fetcher}, 32'd1);
        check32({tag, "_inst"}, inst_to_fetcher, exp_inst);
        check32({tag, "_novmem"}, {31'd0, valid_to_mem}, 32'd0);
        @(negedge clk);
        check32({tag, "_pulse_end"}, {31'd0, ready_to_fetcher}, 32'd0);
    endtask

    initial begin
        rst_n              = 1'b0;
        rdy                = 1'b1;
        flush              = 1'b0;
        valid_from_fetcher = 1'b0;
        addr_from_fetcher  = 32'h0000_0000;
        ready_from_mem     = 1'b0;
        data_from_mem      = 128'd0;
        repeat (3) @(negedge clk);
        check32("rst_ready", {31'd0, ready_to_fetcher}, 32'd0);
        check32("rst_inst", inst_to_fetcher, 32'h0000_0000);
        check32("rst_vmem", {31'd0, valid_to_mem}, 32'd0);
        check32("rst_amem", addr_to_mem, 32'h0000_0000);
        rst_n = 1'b1;

        // Cold miss on word 1, then hits on words 2 and 3.
        fetch_miss("cold", 32'h0000_1004, L1, 18, 32'h4433_2211, 1'b0);
        fetch_hit("hit2", 32'h0000_1008, 32'hDDCC_BBAA);
        fetch_hit("hit3", 32'h0000_100C, 32'h3322_1100);

        // Conflict: 0x2000 maps onto the same index as 0x1000.
        fetch_hit("hit0", 32'h0000_1000, 32'h8877_6655);
        fetch_miss("confl", 32'h0000_2000, L2, 4, 32'h0302_0100, 1'b0);
        fetch_miss("evict", 32'h0000_1000, L1, 3, 32'h8877_6655, 1'b0);

        // Flush three cycles into a fill. The fill finishes, but nothing is installed or answered.
        @(negedge clk);
        valid_from_fetcher = 1'b1;
        addr_from_fetcher  = 32'h0000_3004;
        @(negedge clk);
        check32("fl_vmem", {31'd0, valid_to_mem}, 32'd1);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check32("fl_vmem_held", {31'd0, valid_to_mem}, 32'd1);
        repeat (3) @(negedge clk);
        check32("fl_vmem_held2", {31'd0, valid_to_mem}, 32'd1);
        check32("fl_amem_held", addr_to_mem, 32'h0000_3000);
        ready_from_mem     = 1'b1;
        data_from_mem      = L3;
        valid_from_fetcher = 1'b0;
        @(negedge clk);
        ready_from_mem = 1'b0;
        check32("fl_noready", {31'd0, ready_to_fetcher}, 32'd0);
        check32("fl_vmem_drop", {31'd0, valid_to_mem}, 32'd0);
        @(negedge clk);
        check32("fl_noready2", {31'd0, ready_to_fetcher}, 32'd0);
        fetch_miss("fl_refetch", 32'h0000_3004, L3, 5, 32'h1234_5678, 1'b0);
        fetch_miss("fl_cleared", 32'h0000_1000, L1, 3, 32'h8877_6655, 1'b0);
        // A flush in the same cycle as a request that would hit turns it into a miss.
        fetch_miss("fl_same", 32'h0000_1000, L1, 2, 32'h8877_6655, 1'b1);

        // rdy low for 5 cycles during a fill, then again while the response pulse is up.
        @(negedge clk);
        valid_from_fetcher = 1'b1;
        addr_from_fetcher  = 32'h0000_4008;
        @(negedge clk);
        check32("rdy_vmem", {31'd0, valid_to_mem}, 32'd1);
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("rdy_miss_vmem", {31'd0, valid_to_mem}, 32'd1);
            check32("rdy_miss_amem", addr_to_mem, 32'h0000_4000);
        end
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        ready_from_mem = 1'b1;
        data_from_mem  = L4;
        @(negedge clk);
        ready_from_mem     = 1'b0;
        valid_from_fetcher = 1'b0;
        check32("rdy_ready", {31'd0, ready_to_fetcher}, 32'd1);
        check32("rdy_inst", inst_to_fetcher, 32'h3333_3333);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("rdy_pulse_hold", {31'd0, ready_to_fetcher}, 32'd1);
            check32("rdy_inst_hold", inst_to_fetcher, 32'h3333_3333);
        end
        rdy = 1'b1;
        @(negedge clk);
        check32("rdy_pulse_end", {31'd0, ready_to_fetcher}, 32'd0);
        fetch_hit("rdy_hit", 32'h0000_4008, 32'h3333_3333);

        // Asynchronous reset between clock edges while a fill is outstanding.
        @(negedge clk);
        valid_from_fetcher = 1'b1;
        addr_from_fetcher  = 32'h0000_5000;
        @(negedge clk);
        check32("ar_vmem_pre", {31'd0, valid_to_mem}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check32("ar_vmem", {31'd0, valid_to_mem}, 32'd0);
        check32("ar_amem", addr_to_mem, 32'h0000_0000);
        check32("ar_ready", {31'd0, ready_to_fetcher}, 32'd0);
        valid_from_fetcher = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fetch_miss("ar_miss4", 32'h0000_4008, L4, 3, 32'h3333_3333, 1'b0);
        fetch_miss("ar_miss3", 32'h0000_300C, L3, 2, 32'hCAFE_F00D, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
